// File: rtl/dnn_result_collector.sv
// Pairs the two DNN output strobes into (class, max, |diff|) results and
// queues them in a small FIFO for a downstream consumer.
module dnn_result_collector #(
    parameter int DEPTH = 4,
    parameter int DW    = 17
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in0_ready,
    input  logic signed [DW-1:0]     in0,
    input  logic                     in1_ready,
    input  logic signed [DW-1:0]     in1,
    input  logic                     flush,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic                     res_class,
    output logic signed [DW-1:0]     res_max,
    output logic [DW:0]              res_margin,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     unpaired
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, HAVE0, HAVE1} state_t;

    state_t                state, state_nxt;
    logic signed [DW-1:0]  p0, p1;
    logic signed [DW-1:0]  pair_a, pair_b;
    logic                  pair_push, load_p0, load_p1, set_unp;

    // NOTE: every output of this block gets a default first, so no path leaves one unassigned and infers a latch.
    always_comb begin
        state_nxt = state;
        pair_push = 1'b0;
        pair_a    = in0;
        pair_b    = in1;
        load_p0   = 1'b0;
        load_p1   = 1'b0;
        set_unp   = 1'b0;
        if (flush) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (in0_ready && in1_ready) begin
                        pair_push = 1'b1;
                    end else if (in0_ready) begin
                        load_p0   = 1'b1;
                        state_nxt = HAVE0;
                    end else if (in1_ready) begin
                        load_p1   = 1'b1;
                        state_nxt = HAVE1;
                    end
                end
                HAVE0: begin
                    pair_a = p0;
                    if (in1_ready) begin
                        pair_push = 1'b1;
                        state_nxt = IDLE;
                    end
                    // A fresh in0 replaces the pending one (after it was paired, if in1 also arrived).
                    if (in0_ready) begin
                        load_p0   = 1'b1;
                        set_unp   = 1'b1;
                        state_nxt = HAVE0;
                    end
                end
                HAVE1: begin
                    pair_b = p1;
                    if (in0_ready) begin
                        pair_push = 1'b1;
                        state_nxt = IDLE;
                    end
                    if (in1_ready) begin
                        load_p1   = 1'b1;
                        set_unp   = 1'b1;
                        state_nxt = HAVE1;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Pair result: tie goes to class 0; margin is exact in DW+1 bits.
    logic signed [DW:0] diff;
    logic               pair_class;
    logic signed [DW-1:0] pair_max;
    logic [DW:0]        pair_margin;

    always_comb begin
        diff        = {pair_a[DW-1], pair_a} - {pair_b[DW-1], pair_b};
        pair_class  = (pair_b > pair_a);
        pair_max    = pair_class ? pair_b : pair_a;
        pair_margin = diff[DW] ? -diff : diff;
    end

    // FIFO storage and control.
    logic              mem_class  [DEPTH];
    logic [DW-1:0]     mem_max    [DEPTH];
    logic [DW:0]       mem_margin [DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic              full, do_pop, do_push, drop;

    assign full    = (count == CW'(DEPTH));
    assign do_pop  = res_valid && res_ready;
    assign do_push = pair_push && (!full || do_pop);
    assign drop    = pair_push && full && !do_pop;

    // NOTE: the storage array has no reset; the head outputs are masked by res_valid so stale entries never show.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_class[wr_ptr]  <= pair_class;
            mem_max[wr_ptr]    <= pair_max;
            mem_margin[wr_ptr] <= pair_margin;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p0 <= '0;
            p1 <= '0;
        end else begin
            if (load_p0) p0 <= in0;
            if (load_p1) p1 <= in1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            unpaired <= 1'b0;
        end else if (flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            unpaired <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (drop)    overflow <= 1'b1;
            if (set_unp) unpaired <= 1'b1;
        end
    end

    assign res_valid  = (count != '0);
    assign res_class  = res_valid && mem_class[rd_ptr];
    assign res_max    = res_valid ? mem_max[rd_ptr] : '0;
    assign res_margin = res_valid ? mem_margin[rd_ptr] : '0;

endmodule

// File: doc/dnn_result_collector.md
DNN_RESULT_COLLECTOR -- requirements
Module: dnn_result_collector

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning result FIFO entries (power of two, 2..16).
REQ-002 SHALL have parameter DW, default 17, meaning signed width of each DNN output value.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port in0_ready  input  1  one-cycle strobe: in0 valid this cycle.
REQ-006 SHALL have port in0  input  DW  signed DNN output 0.
REQ-007 SHALL have port in1_ready  input  1  one-cycle strobe: in1 valid this cycle.
REQ-008 SHALL have port in1  input  DW  signed DNN output 1.
REQ-009 SHALL have port flush  input  1  synchronous clear of pairing state and FIFO.
REQ-010 SHALL have port res_valid  output  1  FIFO head holds a result.
REQ-011 SHALL have port res_ready  input  1  consumer accepts head when res_valid=1.
REQ-012 SHALL have port res_class  output  1  winning output index (0 or 1).
REQ-013 SHALL have port res_max  output  DW  signed winning value.
REQ-014 SHALL have port res_margin  output  DW+1  unsigned |in0-in1|.
REQ-015 SHALL have port count  output  $clog2(DEPTH)+1  FIFO occupancy.
REQ-016 SHALL have port overflow  output  1  sticky: completed pair dropped because FIFO full.
REQ-017 SHALL have port unpaired  output  1  sticky: strobe overwrote a still-pending value.

Function
REQ-018 SHALL pair in0/in1 with FSM states IDLE, HAVE0, HAVE1; pending value registers p0, p1.
REQ-019 IDLE: both strobes -> pair formed, stay IDLE; in0_ready only -> p0<=in0, HAVE0; in1_ready only -> p1<=in1, HAVE1.
REQ-020 HAVE0: in1_ready -> pair (p0, in1), IDLE; in0_ready alone -> p0<=in0, set unpaired, stay HAVE0; both strobes -> pair (p0, in1), p0<=in0, set unpaired, stay HAVE0.
REQ-021 HAVE1: mirror of REQ-020 with roles of 0/1 swapped.
REQ-022 Pair result SHALL be: class=1 iff in1>in0 (signed), tie gives class 0; max=larger value; margin=|in0-in1| computed in DW+1 bits, no saturation.
REQ-023 Formed pair SHALL be written to FIFO at the same clock edge; res_valid SHALL rise the cycle after the cycle in which the completing strobe is presented (latency 1).
REQ-024 res_valid SHALL equal (count!=0); res_class/res_max/res_margin SHALL reflect FIFO head, stable while res_valid=1 and res_ready=0.
REQ-025 Pop SHALL occur on an edge where res_valid=1 and res_ready=1; res_ready while empty has no effect.
REQ-026 Push when full without simultaneous pop: pair dropped, FIFO unchanged, overflow set.
REQ-027 Push when full with simultaneous pop: both performed, count unchanged, no overflow.
REQ-028 Pointers SHALL wrap modulo DEPTH; count SHALL range 0..DEPTH.
REQ-029 flush SHALL, at the next edge, empty FIFO, return FSM to IDLE, clear overflow and unpaired; strobes in the flush cycle are ignored; flush has priority over push/pop.
REQ-030 overflow and unpaired SHALL remain set until reset or flush.

Reset
REQ-031 rst_n=0 SHALL immediately force FSM IDLE, count=0, res_valid=0, res_class=0, res_max=0, res_margin=0, overflow=0, unpaired=0, pointers 0, p0=p1=0.
REQ-032 Reset asserted mid-pair or with FIFO non-empty SHALL discard all pending and stored data; first strobe after release starts a fresh pair.

Verification
REQ-033 Same-cycle strobes in0=5, in1=-3, res_ready=1 -> next cycle res_valid=1, class=0, max=5, margin=8; popped, count returns 0.
REQ-034 in1=100 at cycle t, in0=-65536 at t+2 -> res_valid at t+3, class=1, max=100, margin=65636; no unpaired.
REQ-035 in0=7 at t, in0=9 at t+1, in1=9 at t+2 -> unpaired=1; one result: class=0 (tie), max=9, margin=0.
REQ-036 DEPTH=4, res_ready=0, five pairs -> count=4, overflow=1, head is first pair; then res_ready=1 with a sixth pair same cycle -> count stays 4, overflow unchanged.
REQ-037 rst_n low asynchronously while HAVE0 and count=2 -> outputs zero before next edge; after release, in1 alone leaves res_valid=0.
REQ-038 flush while count=3, overflow=1 and same-cycle strobes -> next cycle count=0, res_valid=0, overflow=0, FSM IDLE.
